// File: rtl/spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_master : mode-0 SPI master, 16-bit {addr, rw, data} frames, MSB first. |
// | Optional macro SPI_MASTER_CS_GAP_EN adds a CS_GAP-cycle chip-select gap.   |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module spi_master #(
    parameter int HALF_PERIOD = 2,
    parameter int CS_GAP      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk_pin,
    output logic       cs_pin,
    output logic       mosi_pin,
    input  logic       miso_pin
);

    localparam int CW = $clog2(HALF_PERIOD + 1);
    localparam logic [CW-1:0] c_phase_last = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] c_cnt_one    = CW'(1);
    localparam logic [4:0]    c_last_bit   = 5'd16;
    localparam logic [4:0]    c_tail_bit   = 5'd17;
`ifdef SPI_MASTER_CS_GAP_EN
    localparam int GW = $clog2(CS_GAP + 1);
    localparam logic [GW-1:0] c_gap_last = GW'(CS_GAP - 1);
    localparam logic [GW-1:0] c_gap_one  = GW'(1);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_TRAIL = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t        r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [4:0]    r_bits, w_bits_n;
    logic [14:0]   r_tx, w_tx_n;
    logic [7:0]    r_rx, w_rx_n;
    logic          r_rw, w_rw_n;
    logic          r_sclk, w_sclk_n;
    logic          r_cs, w_cs_n;
    logic          r_mosi, w_mosi_n;
    logic          r_busy, w_busy_n;
    logic          r_done, w_done_n;
    logic [7:0]    r_rdata, w_rdata_n;
    logic          w_phase_end;
`ifdef SPI_MASTER_CS_GAP_EN
    logic [GW-1:0] r_gap, w_gap_n;
`endif

    assign w_phase_end = (r_cnt == c_phase_last);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_bits_n  = r_bits;
        w_tx_n    = r_tx;
        w_rx_n    = r_rx;
        w_rw_n    = r_rw;
        w_sclk_n  = r_sclk;
        w_cs_n    = r_cs;
        w_mosi_n  = r_mosi;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        w_rdata_n = r_rdata;
`ifdef SPI_MASTER_CS_GAP_EN
        w_gap_n   = r_gap;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // Bit 15 goes straight to the pin; the shifter holds bits 14..0.
                    w_tx_n    = {addr[5:0], rw, (rw ? 8'h00 : wdata)};
                    w_rw_n    = rw;
                    w_mosi_n  = addr[6];
                    w_cs_n    = 1'b0;
                    w_busy_n  = 1'b1;
                    w_cnt_n   = '0;
                    w_bits_n  = '0;
                    w_state_n = S_LEAD;
                end
            end
            S_LEAD: begin
                if (w_phase_end) begin
                    w_cnt_n   = '0;
                    w_sclk_n  = 1'b1;
                    w_bits_n  = r_bits + 5'd1;
                    w_rx_n    = {r_rx[6:0], miso_pin};
                    w_state_n = S_SHIFT;
                end else begin
                    w_cnt_n = r_cnt + c_cnt_one;
                end
            end
            S_SHIFT: begin
                if (w_phase_end) begin
                    w_cnt_n = '0;
                    if (r_sclk) begin
                        w_sclk_n = 1'b0;
                        if (r_bits == c_last_bit) begin
                            w_mosi_n  = 1'b0;
                            w_state_n = S_TRAIL;
                        end else begin
                            w_mosi_n = r_tx[14];
                            w_tx_n   = {r_tx[13:0], 1'b0};
                        end
                    end else begin
                        w_sclk_n = 1'b1;
                        w_bits_n = r_bits + 5'd1;
                        w_rx_n   = {r_rx[6:0], miso_pin};
                    end
                end else begin
                    w_cnt_n = r_cnt + c_cnt_one;
                end
            end
            S_TRAIL: begin
                // Two phases: the final sclk low phase, then the chip-select hold.
                if (w_phase_end) begin
                    w_cnt_n = '0;
                    if (r_bits == c_last_bit) begin
                        w_bits_n = c_tail_bit;
                    end else begin
                        w_cs_n   = 1'b1;
                        w_done_n = 1'b1;
                        if (r_rw) begin
                            w_rdata_n = r_rx;
                        end
`ifdef SPI_MASTER_CS_GAP_EN
                        w_gap_n   = '0;
                        w_state_n = S_GAP;
`else
                        w_busy_n  = 1'b0;
                        w_state_n = S_IDLE;
`endif
                    end
                end else begin
                    w_cnt_n = r_cnt + c_cnt_one;
                end
            end
`ifdef SPI_MASTER_CS_GAP_EN
            S_GAP: begin
                if (r_gap == c_gap_last) begin
                    w_busy_n  = 1'b0;
                    w_state_n = S_IDLE;
                end else begin
                    w_gap_n = r_gap + c_gap_one;
                end
            end
`endif
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_rw    <= 1'b0;
            r_sclk  <= 1'b0;
            r_cs    <= 1'b1;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= 8'h00;
`ifdef SPI_MASTER_CS_GAP_EN
            r_gap   <= '0;
`endif
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bits  <= w_bits_n;
            r_tx    <= w_tx_n;
            r_rx    <= w_rx_n;
            r_rw    <= w_rw_n;
            r_sclk  <= w_sclk_n;
            r_cs    <= w_cs_n;
            r_mosi  <= w_mosi_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_rdata <= w_rdata_n;
`ifdef SPI_MASTER_CS_GAP_EN
            r_gap   <= w_gap_n;
`endif
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign sclk_pin = r_sclk;
    assign cs_pin   = r_cs;
    assign mosi_pin = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_master : randomized directed bench for spi_master with a behavioural |
// | register-memory slave. Revision: 1.0                                        |
// +----------------------------------------------------------------------------+
module tb_spi_master;

    localparam int HP     = 2;
    localparam int GAP    = 4;
    localparam int CS_LOW = 34 * HP;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, sclk_pin, cs_pin, mosi_pin;
    logic [7:0] rdata;
    logic       miso_pin = 1'b0;

    int checks = 0;
    int failures = 0;

    spi_master #(.HALF_PERIOD(HP), .CS_GAP(GAP)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rw       (rw),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .sclk_pin (sclk_pin),
        .cs_pin   (cs_pin),
        .mosi_pin (mosi_pin),
        .miso_pin (miso_pin)
    );

    always #5 clk = ~clk;

    // Slave / monitor state, updated on the falling clk edge.
    logic [7:0]  mem [128];
    logic [15:0] cap = '0;
    logic [7:0]  byte_out = '0;
    logic        hdr_rw = 1'b0;
    logic        force_en = 1'b0;
    logic [7:0]  force_byte = 8'h00;
    logic        sclk_q = 1'b0, cs_q = 1'b1, mosi_q = 1'b0;
    int          rise_cnt = 0;
    int          cs_low = 0;
    int          done_cnt = 0;
    int          mode_err = 0;
    int          data_mosi_err = 0;
    logic [7:0]  exp_rdata = 8'h00;

    always @(negedge clk) begin
        if (cs_q && !cs_pin) begin
            rise_cnt = 0;
            cap      = '0;
            hdr_rw   = 1'b0;
            miso_pin = 1'b0;
        end
        if (!cs_pin && sclk_pin && !sclk_q) begin
            rise_cnt = rise_cnt + 1;
            cap      = {cap[14:0], mosi_pin};
            if (rise_cnt == 8) begin
                hdr_rw   = cap[0];
                byte_out = force_en ? force_byte : mem[cap[7:1]];
            end
            if (rise_cnt == 16 && !cap[8]) mem[cap[15:9]] = cap[7:0];
        end
        if (!cs_pin && !sclk_pin && sclk_q && rise_cnt >= 8 && rise_cnt < 16)
            miso_pin = hdr_rw ? byte_out[15 - rise_cnt] : 1'b0;
        if (sclk_pin && sclk_q && (mosi_pin != mosi_q)) mode_err = mode_err + 1;
        if (!cs_pin && hdr_rw && mosi_pin && (rise_cnt >= 9 || (rise_cnt == 8 && !sclk_pin)))
            data_mosi_err = data_mosi_err + 1;
        if (!cs_pin) cs_low = cs_low + 1;
        if (done) done_cnt = done_cnt + 1;
        sclk_q = sclk_pin;
        cs_q   = cs_pin;
        mosi_q = mosi_pin;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks = checks + 1;
        assert (obs === exp_v) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One full transaction; poke_at > 0 pulses a stray start on that frame cycle.
    task automatic run_txn(input logic t_rw, input logic [6:0] t_addr,
                           input logic [7:0] t_wdata, input int poke_at);
        logic [15:0] exp_frame;
        logic [7:0]  exp_rd;
        int          n;
        logic        got;
        exp_frame = {t_addr, t_rw, (t_rw ? 8'h00 : t_wdata)};
        exp_rd    = t_rw ? (force_en ? force_byte : mem[t_addr]) : exp_rdata;
        @(posedge clk); #1;
        rw = t_rw; addr = t_addr; wdata = t_wdata; start = 1'b1;
        cs_low = 0; done_cnt = 0; data_mosi_err = 0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("accept_busy", busy, 1);
        chk("accept_cs", cs_pin, 0);
        chk("first_mosi", mosi_pin, t_addr[6]);
        n = 1;
        got = 1'b0;
        while (n < 300 && !got) begin
            if (n == poke_at) begin
                start = 1'b1; rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n = n + 1;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        chk("done_cs_high", cs_pin, 1);
        chk("done_busy_low", busy, 0);
        chk("rdata", rdata, exp_rd);
        @(negedge clk);
        chk("frame", cap, exp_frame);
        chk("rises", rise_cnt, 16);
        chk("cs_low_cycles", cs_low, CS_LOW);
        chk("done_pulses", done_cnt, 1);
        if (t_rw) chk("read_data_mosi_zero", data_mosi_err, 0);
        else      chk("mem_written", mem[t_addr], t_wdata);
        exp_rdata = exp_rd;
    endtask

    initial begin
        int   n;
        int   gapc;
        logic got;
        logic [6:0] a;
        logic [7:0] d;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_cs", cs_pin, 1);
        chk("rst_sclk", sclk_pin, 0);
        chk("rst_mosi", mosi_pin, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 8'h00);

        // Directed write then read-back of the same register.
        run_txn(1'b0, 7'b0011101, 8'hAA, 0);
        run_txn(1'b1, 7'b0011101, 8'h00, 0);
        chk("mem_unchanged", mem[7'b0011101], 8'hAA);

        // Read with the slave returning a fixed pattern.
        force_en = 1'b1; force_byte = 8'h5C;
        run_txn(1'b1, 7'($urandom), 8'($urandom), 0);
        force_en = 1'b0;

        // Stray start at cycle 10 must not disturb the frame.
        a = 7'($urandom); d = 8'($urandom);
        run_txn(1'b0, a, d, 10);
        run_txn(1'b1, a, 8'h00, 10);

        for (int k = 0; k < 6; k++) begin
            a = 7'($urandom); d = 8'($urandom);
            run_txn(1'b0, a, d, 0);
            run_txn(1'b1, a, 8'($urandom), 0);
            run_txn(1'b1, 7'($urandom), 8'h00, 0);
        end

        // Reset in the middle of a read frame.
        @(posedge clk); #1;
        rw = 1'b1; addr = a; start = 1'b1; done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_cs", cs_pin, 1);
        chk("abort_sclk", sclk_pin, 0);
        chk("abort_busy", busy, 0);
        chk("abort_mosi", mosi_pin, 0);
        chk("abort_rdata", rdata, 8'h00);
        reset = 1'b0;
        exp_rdata = 8'h00;
        repeat (5) @(negedge clk);
        chk("abort_no_resume", cs_pin, 1);
        chk("abort_no_done", done_cnt, 0);
        run_txn(1'b1, a, 8'h00, 0);

        // Back-to-back frames with start held high.
        @(posedge clk); #1;
        rw = 1'b0; addr = 7'($urandom); wdata = 8'($urandom); start = 1'b1;
        n = 0; got = 1'b0;
        while (n < 300 && !got) begin
            @(negedge clk);
            n = n + 1;
            if (done) got = 1'b1;
        end
        chk("b2b_first_done", got, 1);
        gapc = 0;
        while (cs_pin && gapc < 50) begin
            gapc = gapc + 1;
            @(negedge clk);
        end
        start = 1'b0;
`ifdef SPI_MASTER_CS_GAP_EN
        chk("b2b_gap", gapc, 1 + GAP);
`else
        chk("b2b_gap", gapc, 1);
`endif
        n = 0; got = 1'b0;
        while (n < 300 && !got) begin
            @(negedge clk);
            n = n + 1;
            if (done) got = 1'b1;
        end
        chk("b2b_second_done", got, 1);
        repeat (10) @(negedge clk);

        chk("mosi_stable_while_sclk_high", mode_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
